// File: rtl/rnd_reaction_timer.sv
// rnd_reaction_timer: reaction-time game round driven by a 4-bit random value.
// A start samples rnd and waits DELAY_MIN + rnd*DELAY_STEP ticks, then lights
// led_go. It then counts ticks until a fresh button edge, reporting the count.
// Early presses raise foul; no press within TIMEOUT_TICKS raises timeout.
module rnd_reaction_timer #(
    parameter int TICK_DIV      = 50000,
    parameter int DELAY_MIN     = 100,
    parameter int DELAY_STEP    = 100,
    parameter int W             = 16,
    parameter int TIMEOUT_TICKS = 2000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         button,
    input  logic [3:0]   rnd,
    output logic         led_go,
    output logic         busy,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         foul,
    output logic         timeout
);

    // The delay counter is sized for the largest possible load (rnd = 15),
    // so the load arithmetic can never wrap.
    localparam int DELAY_MAX = DELAY_MIN + 15 * DELAY_STEP;
    localparam int DW        = $clog2(DELAY_MAX + 1);
    localparam int PW        = $clog2(TICK_DIV);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]  REACT_LAST = W'(TIMEOUT_TICKS - 1);
    localparam logic [DW-1:0] DLY_BASE   = DW'(DELAY_MIN);
    localparam logic [DW-1:0] DLY_STEP   = DW'(DELAY_STEP);
    localparam logic [DW-1:0] DLY_ONE    = DW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ARMED = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [PW-1:0]  presc_q;
    logic [PW-1:0]  presc_d;
    logic [DW-1:0]  delay_q;
    logic [DW-1:0]  delay_d;
    logic [W-1:0]   react_q;
    logic [W-1:0]   react_d;
    logic           button_q;

    logic [W-1:0]   result_d;
    logic           result_valid_d;
    logic           foul_d;
    logic           timeout_d;
    logic           led_go_d;
    logic           busy_d;

    logic           tick;
    logic           btn_rise;
    logic [DW-1:0]  delay_load;

    assign tick       = (presc_q == PRESC_LAST);
    assign btn_rise   = button & ~button_q;
    assign delay_load = DLY_BASE + DW'(rnd) * DLY_STEP;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter updates and next output values.
    always_comb begin
        state_d        = state_q;
        presc_d        = tick ? '0 : presc_q + PW'(1);
        delay_d        = delay_q;
        react_d        = react_q;
        result_d       = result;
        result_valid_d = 1'b0;
        foul_d         = foul;
        timeout_d      = timeout;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    delay_d   = delay_load;
                    foul_d    = 1'b0;
                    timeout_d = 1'b0;
                    presc_d   = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // A press on the final tick still counts as early.
                if (btn_rise) begin
                    foul_d  = 1'b1;
                    state_d = S_DONE;
                end else if (tick) begin
                    if (delay_q == DLY_ONE) begin
                        react_d = '0;
                        presc_d = '0;
                        state_d = S_ARMED;
                    end else begin
                        delay_d = delay_q - DLY_ONE;
                    end
                end
            end
            S_ARMED: begin
                // The press wins over a coincident tick and reports the
                // count before that tick would have incremented it.
                if (btn_rise) begin
                    result_d       = react_q;
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end else if (tick) begin
                    if (react_q == REACT_LAST) begin
                        result_d       = '1;
                        result_valid_d = 1'b1;
                        timeout_d      = 1'b1;
                        state_d        = S_DONE;
                    end else begin
                        react_d = react_q + W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        led_go_d = (state_d == S_ARMED);
        busy_d   = (state_d == S_WAIT) || (state_d == S_ARMED);
    end

    // Counters, button history and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            delay_q      <= '0;
            react_q      <= '0;
            button_q     <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            foul         <= 1'b0;
            timeout      <= 1'b0;
            led_go       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            delay_q      <= delay_d;
            react_q      <= react_d;
            button_q     <= button;
            result       <= result_d;
            result_valid <= result_valid_d;
            foul         <= foul_d;
            timeout      <= timeout_d;
            led_go       <= led_go_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_rnd_reaction_timer.sv
// Bench for rnd_reaction_timer: directed and randomized rounds, each checked
// cycle by cycle against expectations derived from the round's timing rules.
module tb_rnd_reaction_timer;

    localparam int TD   = 4;
    localparam int DMIN = 2;
    localparam int DSTEP = 1;
    localparam int TO   = 20;
    localparam int W    = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         button;
    logic [3:0]   rnd;
    logic         led_go;
    logic         busy;
    logic [W-1:0] result;
    logic         result_valid;
    logic         foul;
    logic         timeout;

    int           nchk = 0;
    int           npass = 0;
    logic [15:0]  prev_result;
    bit           btn_hold = 1'b0;

    rnd_reaction_timer #(
        .TICK_DIV      (TD),
        .DELAY_MIN     (DMIN),
        .DELAY_STEP    (DSTEP),
        .W             (W),
        .TIMEOUT_TICKS (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .button       (button),
        .rnd          (rnd),
        .led_go       (led_go),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .foul         (foul),
        .timeout      (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk = nchk + 1;
        assert (obs === exp) npass = npass + 1;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_all(input string tag, input bit e_led, input bit e_busy,
                             input logic [15:0] e_res, input bit e_rv,
                             input bit e_foul, input bit e_to);
        check({tag, " led_go"}, 32'(led_go), 32'(e_led));
        check({tag, " busy"}, 32'(busy), 32'(e_busy));
        check({tag, " result"}, 32'(result), 32'(e_res));
        check({tag, " result_valid"}, 32'(result_valid), 32'(e_rv));
        check({tag, " foul"}, 32'(foul), 32'(e_foul));
        check({tag, " timeout"}, 32'(timeout), 32'(e_to));
    endtask

    // One game round. p is the offset (in cycles after the start-sampling
    // edge) of the edge that samples the button rise; 0 means no press.
    task automatic run_round(input int r, input int p, input bit noisy);
        int n, arm, endoff, res;
        bit is_foul, is_to;
        n   = DMIN + r * DSTEP;
        arm = n * TD;
        if (p != 0 && p <= arm) begin
            is_foul = 1; is_to = 0; endoff = p; res = int'(prev_result);
        end else if (p != 0 && (p - arm) <= TO * TD) begin
            is_foul = 0; is_to = 0; endoff = p; res = (p - arm - 1) / TD;
        end else begin
            is_foul = 0; is_to = 1; endoff = arm + TO * TD; res = 16'hFFFF;
        end

        @(negedge clock);
        start = 1'b1;
        rnd   = r[3:0];
        if (!btn_hold) button = 1'b0;

        for (int t = 0; t <= endoff + 2; t++) begin
            @(negedge clock);
            check_all($sformatf("rnd%0d p%0d t%0d", r, p, t),
                      !is_foul && t >= arm && t < endoff,
                      t < endoff,
                      (t >= endoff && !is_foul) ? res[15:0] : prev_result,
                      t == endoff && !is_foul,
                      is_foul && t >= endoff,
                      is_to && t >= endoff);
            if (noisy && t + 1 < endoff) begin
                start = 1'($urandom_range(0, 1));
                rnd   = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            if (btn_hold)
                button = button | (p != 0 && t + 1 >= p);
            else
                button = (p != 0 && t + 1 >= p && t + 1 <= p + 2);
        end
        if (!is_foul) prev_result = res[15:0];
    endtask

    initial begin
        int r, p, sel;
        reset  = 1'b1;
        start  = 1'b0;
        button = 1'b0;
        rnd    = 4'd0;
        prev_result = 16'h0000;

        repeat (3) @(negedge clock);
        check_all("in_reset", 0, 0, 16'h0, 0, 0, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_all("idle", 0, 0, 16'h0, 0, 0, 0);

        // Normal press at EA+13 with rnd=5: led_go at E0+28, result 3.
        run_round(5, 28 + 13, 0);
        // Early press at E0+10.
        run_round(5, 10, 0);
        // Press on an ARMED tick with react_cnt=2; also shows foul cleared.
        run_round(5, 28 + 12, 0);
        // No press with rnd=0: ARMED at 8, timeout at 88.
        run_round(0, 0, 0);
        // Press on the final WAIT tick edge.
        run_round(3, (DMIN + 3) * TD, 0);
        // Press on the same edge the timeout would fire.
        run_round(2, (DMIN + 2) * TD + TO * TD, 0);
        // start and rnd toggled while busy must not disturb the round.
        run_round(4, (DMIN + 4) * TD + 30, 1);

        // Button held high across a round boundary: second round sees no edge.
        btn_hold = 1'b1;
        run_round(1, (DMIN + 1) * TD + 5, 0);
        run_round(0, 0, 0);
        btn_hold = 1'b0;

        for (int k = 0; k < 8; k++) begin
            r   = $urandom_range(0, 15);
            sel = $urandom_range(0, 9);
            p   = (sel == 0) ? 0 : $urandom_range(1, (DMIN + r * DSTEP) * TD + TO * TD + 3);
            run_round(r, p, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of ARMED.
        @(negedge clock);
        start = 1'b1;
        rnd   = 4'd0;
        button = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (12) @(negedge clock);
        check_all("before_reset", 1, 1, prev_result, 0, 0, 0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check_all("async_reset", 0, 0, 16'h0, 0, 0, 0);
        @(negedge clock);
        check_all("held_reset", 0, 0, 16'h0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        prev_result = 16'h0000;
        repeat (2) @(negedge clock);
        check_all("after_reset", 0, 0, 16'h0, 0, 0, 0);

        run_round(1, (DMIN + 1) * TD + 9, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
